// File: rtl/dig_gain_pkg.sv
// Shared types and defaults for the digital gain AGC controller.
// Holds the FSM state encoding, channel indices and coefficient limits.
package dig_gain_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CAPTURE     = 2'd1,
    ADJUST      = 2'd2,
    WAIT_COMMIT = 2'd3
  } agc_state_e;

  localparam int CH_I   = 0;
  localparam int CH_Q   = 1;
  localparam int CH_U   = 2;
  localparam int CH_V   = 3;
  localparam int NUM_CH = 4;

  localparam logic [15:0] COEFF_INIT_DEF = 16'h4000;
  localparam logic [15:0] COEFF_MIN_DEF  = 16'h0010;
  localparam logic [15:0] COEFF_MAX_DEF  = 16'hFFF0;

  function automatic logic at_clamp(input logic [15:0] c,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (c == lo) || (c == hi);
  endfunction

endpackage

// File: rtl/gain_step_unit.sv
// Single-channel gain decision: compare peak to window, step coefficient, clamp.
// Purely combinational; the controller time-shares one instance across channels.
module gain_step_unit #(
  parameter logic [15:0] COEFF_MIN = 16'h0010,
  parameter logic [15:0] COEFF_MAX = 16'hFFF0,
  parameter int unsigned STEP_SH   = 4
) (
  input  logic [15:0] i_coeff,
  input  logic [31:0] i_pk,
  input  logic [31:0] i_hi_th,
  input  logic [31:0] i_lo_th,
  output logic [15:0] o_pend
);

  logic [15:0] w_shift;
  logic [15:0] w_step;
  logic [16:0] w_sum;
  logic [16:0] w_diff;

  assign w_shift = i_coeff >> STEP_SH;
  assign w_step  = (w_shift == 16'd0) ? 16'd1 : w_shift;
  // 17-bit arithmetic so neither direction can wrap before clamping
  assign w_sum   = {1'b0, i_coeff} + {1'b0, w_step};
  assign w_diff  = {1'b0, i_coeff} - {1'b0, w_step};

  always_comb begin
    o_pend = i_coeff;
    if (i_pk > i_hi_th) begin
      if (w_diff[16] || (w_diff[15:0] < COEFF_MIN)) o_pend = COEFF_MIN;
      else                                          o_pend = w_diff[15:0];
    end else if (i_pk < i_lo_th) begin
      if (w_sum > {1'b0, COEFF_MAX}) o_pend = COEFF_MAX;
      else                           o_pend = w_sum[15:0];
    end
  end

endmodule

// File: rtl/digital_gain_agc_ctrl.sv
// Frame-based AGC for the four-channel digital gain stage; commits coefficients on frame ends.
// Optional manual override when GAIN_CTRL_MANUAL_EN is defined.
//   state       | meaning
//   IDLE        | waiting for a frame end (counts down hold frames)
//   CAPTURE     | peaks latched from the frame-end cycle
//   ADJUST      | one channel per cycle through the shared step unit
//   WAIT_COMMIT | pending values ready, applied on the next frame end
module digital_gain_agc_ctrl
  import dig_gain_pkg::*;
#(
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned FRAME_LAST  = 511,
  parameter logic [15:0] COEFF_INIT  = COEFF_INIT_DEF,
  parameter logic [15:0] COEFF_MIN   = COEFF_MIN_DEF,
  parameter logic [15:0] COEFF_MAX   = COEFF_MAX_DEF,
  parameter int unsigned STEP_SH     = 4,
  parameter int unsigned HOLD_FRAMES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             agc_en,
  input  logic [31:0]      hi_th,
  input  logic [31:0]      lo_th,
  input  logic             en_sync_in,
  input  logic [CNT_W-1:0] cnt_sync_in,
  input  logic [31:0]      max_I,
  input  logic [31:0]      max_Q,
  input  logic [31:0]      max_U,
  input  logic [31:0]      max_V,
`ifdef GAIN_CTRL_MANUAL_EN
  input  logic             man_en,
  input  logic [15:0]      man_coeff_I,
  input  logic [15:0]      man_coeff_Q,
  input  logic [15:0]      man_coeff_U,
  input  logic [15:0]      man_coeff_V,
`endif
  output logic [15:0]      scaled_coeff_I,
  output logic [15:0]      scaled_coeff_Q,
  output logic [15:0]      scaled_coeff_U,
  output logic [15:0]      scaled_coeff_V,
  output logic             coeff_upd,
  output logic [3:0]       sat_flag,
  output logic             busy
);

  localparam int unsigned HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  agc_state_e        r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [1:0]        r_ch;
  logic [31:0]       r_pk       [NUM_CH];
  logic [15:0]       r_pend     [NUM_CH];
  logic [15:0]       r_coeff    [NUM_CH];
  logic              r_upd;
  logic [3:0]        r_sat;

  logic              w_fe;
  logic              w_commit;
  logic              w_load;
  logic              w_diff;
  logic              w_man_en;
  logic [3:0]        w_sat_nxt;
  logic [15:0]       w_step_out;
  logic [31:0]       w_max      [NUM_CH];
  logic [15:0]       w_man_coeff[NUM_CH];
  logic [15:0]       w_load_val [NUM_CH];

  assign w_fe = en_sync_in && (cnt_sync_in == CNT_W'(FRAME_LAST));

  assign w_max[CH_I] = max_I;
  assign w_max[CH_Q] = max_Q;
  assign w_max[CH_U] = max_U;
  assign w_max[CH_V] = max_V;

`ifdef GAIN_CTRL_MANUAL_EN
  assign w_man_en          = man_en;
  assign w_man_coeff[CH_I] = man_coeff_I;
  assign w_man_coeff[CH_Q] = man_coeff_Q;
  assign w_man_coeff[CH_U] = man_coeff_U;
  assign w_man_coeff[CH_V] = man_coeff_V;
`else
  assign w_man_en = 1'b0;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) w_man_coeff[i] = 16'd0;
  end
`endif

  gain_step_unit #(
    .COEFF_MIN (COEFF_MIN),
    .COEFF_MAX (COEFF_MAX),
    .STEP_SH   (STEP_SH)
  ) u_step (
    .i_coeff (r_coeff[r_ch]),
    .i_pk    (r_pk[r_ch]),
    .i_hi_th (hi_th),
    .i_lo_th (lo_th),
    .o_pend  (w_step_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    w_diff      = 1'b0;
    w_sat_nxt   = r_sat;
    for (int i = 0; i < NUM_CH; i++) w_load_val[i] = w_man_en ? w_man_coeff[i] : r_pend[i];

    if (w_man_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:        if (w_fe && agc_en && (r_hold_cnt == '0)) w_state_nxt = CAPTURE;
        CAPTURE:     w_state_nxt = agc_en ? ADJUST : IDLE;
        ADJUST: begin
          if (!agc_en)                          w_state_nxt = IDLE;
          else if (r_ch == 2'(NUM_CH - 1))      w_state_nxt = WAIT_COMMIT;
        end
        WAIT_COMMIT: if (!agc_en || w_fe) w_state_nxt = IDLE;
        default:     w_state_nxt = IDLE;
      endcase
    end

    // A disable in WAIT_COMMIT wins over a coincident frame end
    w_commit = (r_state == WAIT_COMMIT) && agc_en && w_fe && !w_man_en;
    w_load   = w_commit || (w_man_en && w_fe);
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_load_val[i] != r_coeff[i]) w_diff = 1'b1;
      w_sat_nxt[i] = at_clamp(w_load_val[i], COEFF_MIN, COEFF_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= HOLD_W'(HOLD_FRAMES);
      r_ch       <= 2'd0;
      r_upd      <= 1'b0;
      r_sat      <= {NUM_CH{at_clamp(COEFF_INIT, COEFF_MIN, COEFF_MAX)}};
      for (int i = 0; i < NUM_CH; i++) begin
        r_pk[i]    <= 32'd0;
        r_pend[i]  <= COEFF_INIT;
        r_coeff[i] <= COEFF_INIT;
      end
    end else begin
      r_state <= w_state_nxt;
      r_upd   <= 1'b0;

      if (w_load) begin
        r_upd <= w_diff;
        r_sat <= w_sat_nxt;
        for (int i = 0; i < NUM_CH; i++) r_coeff[i] <= w_load_val[i];
      end

      if (w_man_en || w_commit)
        r_hold_cnt <= HOLD_W'(HOLD_FRAMES);
      else if ((r_state == IDLE) && w_fe && (r_hold_cnt != '0))
        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);

      if ((r_state == IDLE) && (w_state_nxt == CAPTURE)) begin
        for (int i = 0; i < NUM_CH; i++) r_pk[i] <= w_max[i];
      end

      if (r_state == ADJUST) begin
        r_pend[r_ch] <= w_step_out;
        r_ch         <= r_ch + 2'd1;
      end else begin
        r_ch <= 2'd0;
      end
    end
  end

  assign scaled_coeff_I = r_coeff[CH_I];
  assign scaled_coeff_Q = r_coeff[CH_Q];
  assign scaled_coeff_U = r_coeff[CH_U];
  assign scaled_coeff_V = r_coeff[CH_V];
  assign coeff_upd      = r_upd;
  assign sat_flag       = r_sat;
  assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_digital_gain_agc_ctrl.sv
// Self-checking bench for digital_gain_agc_ctrl (default build, hold of zero frames).
// A frame-level reference model queues expected commits that are popped on the commit cycle.
module tb_digital_gain_agc_ctrl;

  logic        clk, rst, agc_en;
  logic [31:0] hi_th, lo_th;
  logic        en_sync_in;
  logic [8:0]  cnt_sync_in;
  logic [31:0] max_I, max_Q, max_U, max_V;
  logic [15:0] scaled_coeff_I, scaled_coeff_Q, scaled_coeff_U, scaled_coeff_V;
  logic        coeff_upd;
  logic [3:0]  sat_flag;
  logic        busy;

  digital_gain_agc_ctrl #(.HOLD_FRAMES(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .agc_en         (agc_en),
    .hi_th          (hi_th),
    .lo_th          (lo_th),
    .en_sync_in     (en_sync_in),
    .cnt_sync_in    (cnt_sync_in),
    .max_I          (max_I),
    .max_Q          (max_Q),
    .max_U          (max_U),
    .max_V          (max_V),
    .scaled_coeff_I (scaled_coeff_I),
    .scaled_coeff_Q (scaled_coeff_Q),
    .scaled_coeff_U (scaled_coeff_U),
    .scaled_coeff_V (scaled_coeff_V),
    .coeff_upd      (coeff_upd),
    .sat_flag       (sat_flag),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] c;
    logic        upd;
    logic [3:0]  sat;
  } exp_t;

  exp_t        exp_q[$];
  int          errors, checks;
  logic [31:0] pk      [4];
  logic [15:0] m_coeff [4];
  logic [15:0] m_pend  [4];
  logic [3:0]  m_sat;
  bit          m_active;
  int          m_meas, m_k, n_upd;
  bit          seen12;

  function automatic logic [15:0] model_adj(input logic [15:0] c, input logic [31:0] p);
    int s, v;
    s = int'(c) / 16;
    if (s == 0) s = 1;
    v = int'(c);
    if (p > hi_th) begin
      v = int'(c) - s;
      if (v < 16) v = 16;
    end else if (p < lo_th) begin
      v = int'(c) + s;
      if (v > 65520) v = 65520;
    end
    return 16'(v);
  endfunction

  task automatic cyc(input bit fe, input bit decoy = 1'b0);
    exp_t        e;
    bit          commit;
    logic [15:0] old_i;
    logic [67:0] got, want;
    commit = 1'b0;
    old_i  = m_coeff[0];
    en_sync_in  = fe | ~decoy;
    cnt_sync_in = (fe | decoy) ? 9'd511 : 9'(m_k % 500);
    if (fe) begin
      max_I = pk[0]; max_Q = pk[1]; max_U = pk[2]; max_V = pk[3];
    end else begin
      max_I = $urandom(); max_Q = $urandom(); max_U = $urandom(); max_V = $urandom();
    end
    if (rst) begin
      for (int i = 0; i < 4; i++) m_coeff[i] = 16'h4000;
      m_sat    = 4'b0000;
      m_active = 1'b0;
      exp_q.delete();
    end else if (m_active) begin
      if (!agc_en) m_active = 1'b0;
      else if (fe && (m_k - m_meas) >= 6) begin
        e.upd = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (m_pend[i] != m_coeff[i]) e.upd = 1'b1;
          e.sat[i] = (m_pend[i] == 16'h0010) || (m_pend[i] == 16'hFFF0);
        end
        e.c = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) m_coeff[i] = m_pend[i];
        m_sat    = e.sat;
        m_active = 1'b0;
        commit   = 1'b1;
      end
    end else if (fe && agc_en) begin
      for (int i = 0; i < 4; i++) m_pend[i] = model_adj(m_coeff[i], pk[i]);
      m_active = 1'b1;
      m_meas   = m_k;
    end
    m_k++;
    @(negedge clk);
    if (coeff_upd === 1'b1) n_upd++;
    got = {scaled_coeff_V, scaled_coeff_U, scaled_coeff_Q, scaled_coeff_I, sat_flag};
    checks++;
    if (busy !== m_active) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", m_k, busy, m_active);
    end
    if (commit) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty cyc=%0d", m_k);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (got !== {e.c, e.sat}) begin
          errors++;
          $display("FAIL commit_coeffs cyc=%0d got=%h exp=%h", m_k, got, {e.c, e.sat});
        end
        checks++;
        if (coeff_upd !== e.upd) begin
          errors++;
          $display("FAIL commit_upd cyc=%0d got=%b exp=%b", m_k, coeff_upd, e.upd);
        end
      end
      if (old_i == 16'h0012) begin
        seen12 = 1'b1;
        checks++;
        if (scaled_coeff_I !== 16'h0011) begin
          errors++;
          $display("FAIL min_step got=%h exp=0011", scaled_coeff_I);
        end
      end
    end else begin
      want = {m_coeff[3], m_coeff[2], m_coeff[1], m_coeff[0], m_sat};
      checks++;
      if (coeff_upd !== 1'b0) begin
        errors++;
        $display("FAIL spurious_upd cyc=%0d got=%b exp=0", m_k, coeff_upd);
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold_coeffs cyc=%0d got=%h exp=%h", m_k, got, want);
      end
    end
  endtask

  task automatic frame(input int len);
    repeat (len - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic align();
    if (m_active) frame(8);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    chk("reset_I", 32'(scaled_coeff_I), 32'h4000);
    chk("reset_Q", 32'(scaled_coeff_Q), 32'h4000);
    chk("reset_U", 32'(scaled_coeff_U), 32'h4000);
    chk("reset_V", 32'(scaled_coeff_V), 32'h4000);
    chk("reset_upd", 32'(coeff_upd), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_sat", 32'(sat_flag), 32'h0);
  endtask

  task automatic test_over_threshold();
    int n0;
    n0 = n_upd;
    pk[0] = 2000; pk[1] = 500; pk[2] = 500; pk[3] = 500;
    frame(8);
    frame(8);
    chk("over_I", 32'(scaled_coeff_I), 32'h3C00);
    chk("over_Q", 32'(scaled_coeff_Q), 32'h4000);
    chk("over_U", 32'(scaled_coeff_U), 32'h4000);
    chk("over_V", 32'(scaled_coeff_V), 32'h4000);
    chk("over_pulses", 32'(n_upd - n0), 32'd1);
  endtask

  task automatic test_thresholds();
    int n0;
    align();
    n0 = n_upd;
    pk[0] = 1000; pk[1] = 100; pk[2] = 500; pk[3] = 500;
    frame(8);
    frame(8);
    chk("window_edges_pulses", 32'(n_upd - n0), 32'd0);
    chk("window_edge_hi", 32'(scaled_coeff_I), 32'h3C00);
    chk("window_edge_lo", 32'(scaled_coeff_Q), 32'h4000);
    hi_th = 100; lo_th = 200;
    pk[0] = 150; pk[1] = 50; pk[2] = 150; pk[3] = 100;
    frame(8);
    frame(8);
    chk("misconfig_I", 32'(scaled_coeff_I), 32'h3C00 - 32'h03C0);
    chk("misconfig_Q", 32'(scaled_coeff_Q), 32'h4400);
    hi_th = 1000; lo_th = 100;
  endtask

  task automatic test_clamp_high();
    int n0;
    align();
    pk[0] = 500; pk[1] = 500; pk[2] = 500; pk[3] = 10;
    for (int n = 0; n < 40 && m_coeff[3] != 16'hFFF0; n++) begin
      frame(7);
      frame(7);
    end
    chk("clamp_hi_V", 32'(scaled_coeff_V), 32'hFFF0);
    chk("clamp_hi_sat", 32'(sat_flag[3]), 32'h1);
    n0 = n_upd;
    repeat (4) frame(7);
    chk("clamp_hi_no_pulse", 32'(n_upd - n0), 32'd0);
  endtask

  task automatic test_min_step();
    int n0;
    align();
    pk[0] = 5000; pk[1] = 500; pk[2] = 500; pk[3] = 10;
    for (int n = 0; n < 150 && m_coeff[0] != 16'h0010; n++) begin
      frame(6);
      frame(6);
    end
    chk("clamp_lo_I", 32'(scaled_coeff_I), 32'h0010);
    chk("clamp_lo_sat", 32'(sat_flag), 32'b1001);
    chk("min_step_reached", 32'(seen12), 32'h1);
    n0 = n_upd;
    frame(6);
    frame(6);
    chk("clamp_lo_no_pulse", 32'(n_upd - n0), 32'd0);
  endtask

  task automatic test_abort();
    int n0;
    logic [15:0] q0;
    align();
    q0 = m_coeff[1];
    pk[0] = 500; pk[1] = 5000; pk[2] = 500; pk[3] = 500;
    frame(8);
    cyc(1'b0);
    cyc(1'b0);
    agc_en = 1'b0;
    cyc(1'b0);
    chk("abort_busy_drop", 32'(busy), 32'h0);
    agc_en = 1'b1;
    n0 = n_upd;
    frame(8);
    chk("abort_no_commit", 32'(n_upd - n0), 32'd0);
    chk("abort_Q_held", 32'(scaled_coeff_Q), 32'(q0));
    frame(8);
    chk("abort_then_commit", 32'(n_upd - n0), 32'd1);
  endtask

  task automatic test_short_frame();
    int n0;
    align();
    n0 = n_upd;
    pk[1] = 5000;
    frame(8);
    cyc(1'b0);
    cyc(1'b0);
    pk[1] = 500;
    cyc(1'b1);
    chk("short_no_commit", 32'(n_upd - n0), 32'd0);
    chk("short_still_busy", 32'(busy), 32'h1);
    frame(8);
    chk("short_third_commit", 32'(n_upd - n0), 32'd1);
  endtask

  task automatic test_freeze();
    int n0;
    logic [15:0] q0;
    align();
    q0 = m_coeff[1];
    n0 = n_upd;
    pk[1] = 5000;
    agc_en = 1'b0;
    repeat (3) frame(8);
    agc_en = 1'b1;
    repeat (3) cyc(1'b0, 1'b1);
    chk("freeze_no_pulse", 32'(n_upd - n0), 32'd0);
    chk("freeze_Q_held", 32'(scaled_coeff_Q), 32'(q0));
    chk("decoy_not_fe", 32'(busy), 32'h0);
  endtask

  task automatic test_mid_reset();
    align();
    pk[1] = 5000;
    frame(8);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    chk("midrst_I", 32'(scaled_coeff_I), 32'h4000);
    chk("midrst_Q", 32'(scaled_coeff_Q), 32'h4000);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_sat", 32'(sat_flag), 32'h0);
    frame(8);
    frame(8);
  endtask

  initial begin
    errors = 0; checks = 0; m_k = 0; m_meas = 0; n_upd = 0;
    seen12 = 1'b0; m_active = 1'b0; m_sat = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      pk[i] = 500; m_coeff[i] = 16'h4000; m_pend[i] = 16'h4000;
    end
    rst = 1'b1; agc_en = 1'b1; hi_th = 1000; lo_th = 100;
    en_sync_in = 1'b0; cnt_sync_in = 9'd0;
    max_I = 0; max_Q = 0; max_U = 0; max_V = 0;

    test_reset();
    test_over_threshold();
    test_thresholds();
    test_clamp_high();
    test_min_step();
    test_abort();
    test_short_frame();
    test_freeze();
    test_mid_reset();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
